// File: rtl/hd_pkg.sv
// rtl/hd_pkg.sv - shared types, default widths and width helper for the HD similarity datapath
package hd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam int DEF_INPUT_WIDTH = 8;
    localparam int DEF_CHUNKS      = 16;
    localparam int DEF_NUM_CLASSES = 4;
    localparam int DEF_ACC_WIDTH   = 12;

    // Index width for a counter over n items; never narrower than one bit.
    function automatic int class_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/similarity_accumulator_if.sv
// rtl/similarity_accumulator_if.sv - beat input and score/argmax result bundle
//
// slave modport (block side): start, sum_in, sum_valid in;
//   busy, class_score, class_score_valid, done, best_class, best_score, overflow out.
// master modport: the mirror image, used by whatever drives the block.
interface similarity_accumulator_if
    import hd_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES
);
    localparam int CLASS_W = class_w(NUM_CLASSES);

    logic                   start;
    logic [INPUT_WIDTH-1:0] sum_in;
    logic                   sum_valid;
    logic                   busy;
    logic [ACC_WIDTH-1:0]   class_score;
    logic                   class_score_valid;
    logic                   done;
    logic [CLASS_W-1:0]     best_class;
    logic [ACC_WIDTH-1:0]   best_score;
    logic                   overflow;

    modport slave (
        input  start, sum_in, sum_valid,
        output busy, class_score, class_score_valid, done, best_class, best_score, overflow
    );

    modport master (
        output start, sum_in, sum_valid,
        input  busy, class_score, class_score_valid, done, best_class, best_score, overflow
    );
endinterface

// File: rtl/class_argmax.sv
// rtl/class_argmax.sv - running best score/class registers with lower-index tie rule
//
// Ports: clk, reset (sync, active-high); update strobes in score for class_idx;
// first forces the load (first class of a query); best_score/best_class hold the result.
module class_argmax #(
    parameter int ACC_WIDTH = 12,
    parameter int CLASS_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 update,
    input  logic                 first,
    input  logic [CLASS_W-1:0]   class_idx,
    input  logic [ACC_WIDTH-1:0] score,
    output logic [CLASS_W-1:0]   best_class,
    output logic [ACC_WIDTH-1:0] best_score
);
    // Strict greater-than: an equal later score leaves the earlier index in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_class <= '0;
            best_score <= '0;
        end else if (update && (first || (score > best_score))) begin
            best_class <= class_idx;
            best_score <= score;
        end
    end
endmodule

// File: rtl/similarity_accumulator.sv
// rtl/similarity_accumulator.sv - per-class chunk accumulation and running argmax
//
// Ports: clk, reset (sync, active-high), bus (similarity_accumulator_if.slave).
// Build option: ACC_SATURATE_EN clamps a class score at all-ones on overflow;
// without it the score wraps. overflow is flagged either way.
module similarity_accumulator
    import hd_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int CHUNKS      = DEF_CHUNKS,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    similarity_accumulator_if.slave bus
);
    localparam int CLASS_W = class_w(NUM_CLASSES);
    localparam int BEAT_W  = class_w(CHUNKS);
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(CHUNKS - 1);
    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

    acc_state_t state_q, state_d;

    logic [ACC_WIDTH-1:0] acc_q;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [CLASS_W-1:0]   class_cnt;
    logic                 overflow_q;

    logic                 beat_fire;
    logic                 class_end;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] acc_next;

    assign beat_fire = (state_q == ACCUM) && bus.sum_valid;
    assign class_end = beat_fire && (beat_cnt == LAST_BEAT);

    // One guard bit above the score; its carry is the overflow indication.
    assign acc_sum = {1'b0, acc_q} + (ACC_WIDTH + 1)'(bus.sum_in);

`ifdef ACC_SATURATE_EN
    // Once clamped, further positive beats carry again, so the clamp persists.
    assign acc_next = acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
`else
    assign acc_next = acc_sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ACCUM;
            ACCUM:   if (class_end && (class_cnt == LAST_CLASS)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q                 <= '0;
            beat_cnt              <= '0;
            class_cnt             <= '0;
            overflow_q            <= 1'b0;
            bus.class_score       <= '0;
            bus.class_score_valid <= 1'b0;
        end else begin
            bus.class_score_valid <= 1'b0;
            if ((state_q == IDLE) && bus.start) begin
                acc_q      <= '0;
                beat_cnt   <= '0;
                class_cnt  <= '0;
                overflow_q <= 1'b0;
            end else if (beat_fire) begin
                overflow_q <= overflow_q | acc_sum[ACC_WIDTH];
                if (class_end) begin
                    // Clearing here lets the next class's first beat land next cycle.
                    bus.class_score       <= acc_next;
                    bus.class_score_valid <= 1'b1;
                    acc_q                 <= '0;
                    beat_cnt              <= '0;
                    class_cnt             <= class_cnt + 1'b1;
                end else begin
                    acc_q    <= acc_next;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    class_argmax #(
        .ACC_WIDTH (ACC_WIDTH),
        .CLASS_W   (CLASS_W)
    ) u_argmax (
        .clk        (clk),
        .reset      (reset),
        .update     (class_end),
        .first      (class_cnt == '0),
        .class_idx  (class_cnt),
        .score      (acc_next),
        .best_class (bus.best_class),
        .best_score (bus.best_score)
    );

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_similarity_accumulator.sv
// tb/tb_similarity_accumulator.sv - directed table-driven bench for similarity_accumulator
module tb_similarity_accumulator;
    localparam int IW = 8;
    localparam int CH = 4;
    localparam int NC = 3;
    localparam int AW = 8;

`ifdef ACC_SATURATE_EN
    localparam int OVF_S0 = 255;
`else
    localparam int OVF_S0 = 144;
`endif

    typedef struct {
        string name;
        int    v0, v1, v2;
        int    gap;
        int    poke;
        int    s0, s1, s2;
        int    bc, bs, ovf;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[5];

    always #5 clk = ~clk;

    similarity_accumulator_if #(.INPUT_WIDTH(IW), .ACC_WIDTH(AW), .NUM_CLASSES(NC)) bus ();

    similarity_accumulator #(
        .INPUT_WIDTH (IW),
        .CHUNKS      (CH),
        .NUM_CLASSES (NC),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_csv"}, int'(bus.class_score_valid), 0);
        chk({tag, "_class_score"}, int'(bus.class_score), 0);
        chk({tag, "_best_class"}, int'(bus.best_class), 0);
        chk({tag, "_best_score"}, int'(bus.best_score), 0);
        chk({tag, "_overflow"}, int'(bus.overflow), 0);
    endtask

    task automatic run_query(input vec_t v);
        int vals[3];
        int scores[3];
        bit last;
        vals   = '{v.v0, v.v1, v.v2};
        scores = '{v.s0, v.s1, v.s2};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk({v.name, "_busy_rise"}, int'(bus.busy), 1);
        for (int c = 0; c < NC; c++) begin
            for (int b = 0; b < CH; b++) begin
                if (v.poke != 0 && (c * CH + b) == 5) bus.start = 1'b1;
                bus.sum_valid = 1'b1;
                bus.sum_in    = IW'(vals[c]);
                step();
                bus.start     = 1'b0;
                bus.sum_valid = 1'b0;
                last = (b == CH - 1);
                chk($sformatf("%s_csv_c%0d_b%0d", v.name, c, b), int'(bus.class_score_valid), int'(last));
                if (last) chk($sformatf("%s_score_c%0d", v.name, c), int'(bus.class_score), scores[c]);
                chk($sformatf("%s_done_c%0d_b%0d", v.name, c, b), int'(bus.done), int'(last && c == NC - 1));
                if (v.gap != 0 && !(last && c == NC - 1)) begin
                    step();
                    chk($sformatf("%s_gap_csv_c%0d_b%0d", v.name, c, b), int'(bus.class_score_valid), 0);
                end
            end
        end
        chk({v.name, "_best_class"}, int'(bus.best_class), v.bc);
        chk({v.name, "_best_score"}, int'(bus.best_score), v.bs);
        chk({v.name, "_overflow"}, int'(bus.overflow), v.ovf);
        step();
        chk({v.name, "_done_drop"}, int'(bus.done), 0);
        chk({v.name, "_busy_drop"}, int'(bus.busy), 0);
        chk({v.name, "_best_hold"}, int'(bus.best_score), v.bs);
    endtask

    initial begin
        vecs[0] = '{"base",   10, 20, 5,  0, 0, 40, 80, 20, 1, 80, 0};
        vecs[1] = '{"tie",    10, 10, 3,  0, 0, 40, 40, 12, 0, 40, 0};
        vecs[2] = '{"ovf",    100, 1, 1,  0, 0, OVF_S0, 4, 4, 0, OVF_S0, 1};
        vecs[3] = '{"gapped", 10, 20, 5,  1, 0, 40, 80, 20, 1, 80, 0};
        vecs[4] = '{"poke",   10, 20, 5,  0, 1, 40, 80, 20, 1, 80, 0};

        bus.start     = 1'b0;
        bus.sum_valid = 1'b0;
        bus.sum_in    = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_all_zero("reset");

        for (int i = 0; i < 5; i++) run_query(vecs[i]);

        // Beats while idle must not disturb the held result.
        bus.sum_valid = 1'b1;
        bus.sum_in    = IW'(99);
        repeat (3) step();
        bus.sum_valid = 1'b0;
        chk("idle_beats_busy", int'(bus.busy), 0);
        chk("idle_beats_csv", int'(bus.class_score_valid), 0);
        chk("idle_beats_best_class", int'(bus.best_class), 1);
        chk("idle_beats_best_score", int'(bus.best_score), 80);

        // Reset in the middle of a query, after five beats.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.sum_valid = 1'b1;
            bus.sum_in    = IW'(30);
            step();
        end
        bus.sum_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("midreset");
        run_query(vecs[0]);

        // start and reset together: reset wins, block stays idle.
        reset     = 1'b1;
        bus.start = 1'b1;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        step();
        chk("reset_start_busy", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
